nonrestoring_divider: RTL and testbench
=======================================

NONRESTORING_DIVIDER -- requirements
Module: nonrestoring_divider

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port dividend, input, signed 32 bits: numerator, captured at start.
REQ-004 SHALL have port divisor, input, signed 32 bits: denominator, captured at start.
REQ-005 SHALL have port signal_in, input, 1 bit: start request, level-sampled.
REQ-006 SHALL have port quotient, output, signed 32 bits: result, truncated toward zero.
REQ-007 SHALL have port remainder, output, signed 32 bits: result, sign follows dividend.
REQ-008 SHALL have port done_signal, output, 1 bit: high = idle or result valid; low = busy.
REQ-009 SHALL have port addOP, output, 6 bits: count of add operations in last division.
REQ-010 SHALL have port subOP, output, 6 bits: count of subtract operations in last division.
REQ-011 SHALL have port div_by_zero, output, 1 bit, present only under DIVZERO_DETECT_EN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIX, DONE; done_signal high in IDLE and DONE only.
REQ-013 SHALL, in IDLE or DONE with signal_in high at a rising edge, capture operands, clear addOP/subOP, load 32-cycle iteration counter, enter RUN; signal_in held high restarts on every such edge.
REQ-014 SHALL ignore signal_in and input operand changes while in RUN or FIX.
REQ-015 SHALL operate in RUN on magnitudes |dividend|, |divisor| as unsigned 32-bit, with a 33-bit signed partial remainder initialised to 0.
REQ-016 SHALL, per RUN cycle, shift partial remainder left with next quotient-magnitude bit (MSB first); subtract |divisor| if prior remainder >= 0, else add; incrementing subOP or addOP accordingly; quotient bit = 1 if new remainder >= 0.
REQ-017 SHALL perform exactly 32 RUN cycles, then one FIX cycle.
REQ-018 SHALL, in FIX, add |divisor| back if partial remainder < 0 (counting one addOP), then apply signs: quotient negated if operand signs differ, remainder negated if dividend negative.
REQ-019 SHALL register quotient, remainder, addOP, subOP at the FIX edge and enter DONE; done_signal rises 33 cycles after the start-capture edge.
REQ-020 SHALL hold all outputs stable in DONE until the next start.
REQ-021 SHALL guarantee addOP + subOP = 32 or 33; subOP >= 1.
REQ-022 SHALL return quotient 0x80000000, remainder 0 for -2147483648 / -1 (wrap, no flag).
REQ-023 SHALL keep intermediate outputs at previous values while busy; only done_signal changes at start.

Reset
REQ-024 SHALL, on reset_n low, immediately force IDLE, quotient 0, remainder 0, addOP 0, subOP 0, done_signal 1, div_by_zero 0.
REQ-025 SHALL abort any in-progress division on reset with no result produced; first start after reset_n rises behaves as from power-up.

Configuration
REQ-026 SHALL, with DIVZERO_DETECT_EN defined, detect divisor == 0 at start, skip RUN, enter FIX next cycle, output quotient 0xFFFFFFFF, remainder = dividend, addOP 0, subOP 0, div_by_zero 1 (cleared on next start); done_signal rises 2 cycles after capture.
REQ-027 SHALL, without DIVZERO_DETECT_EN, omit div_by_zero and run the normal 33-cycle algorithm for divisor 0: quotient -1 if dividend >= 0, else 1; remainder = dividend.

Verification
REQ-028 SHALL cover 100 / 7 -> quotient 14, remainder 2, done_signal high exactly 33 cycles after start.
REQ-029 SHALL cover -100 / 7 -> -14, -2; 100 / -7 -> -14, 2; -100 / -7 -> 14, -2.
REQ-030 SHALL cover 0 / 1 -> quotient 0, remainder 0, subOP 1, addOP 32.
REQ-031 SHALL cover -2147483648 / -1 -> quotient 0x80000000, remainder 0.
REQ-032 SHALL cover 20000 / 0 in both configurations -> with macro: 0xFFFFFFFF, 20000, div_by_zero 1, 2-cycle latency; without: 0xFFFFFFFF, 20000, 33-cycle latency.
REQ-033 SHALL cover reset_n pulsed low at RUN cycle 10 of 123456 / 3 -> outputs zero, done_signal 1 immediately; subsequent 123456 / 3 -> 41152, 0.

Source files
------------

// File: rtl/nonrestoring_divider.sv
// Signed 32/32 non-restoring divider, one quotient bit per cycle; optional DIVZERO_DETECT_EN adds a div_by_zero flag.
// Latency: done_signal rises 33 cycles after the start-capture edge (2 cycles for divisor 0 with DIVZERO_DETECT_EN).
// Backpressure: none; signal_in is honoured only while done_signal is high and ignored while busy.
module nonrestoring_divider (
    input  logic               clock,
    input  logic               reset_n,
    input  logic signed [31:0] dividend,
    input  logic signed [31:0] divisor,
    input  logic               signal_in,
    output logic signed [31:0] quotient,
    output logic signed [31:0] remainder,
    output logic               done_signal,
    output logic [5:0]         addOP,
    output logic [5:0]         subOP
`ifdef DIVZERO_DETECT_EN
    ,
    output logic               div_by_zero
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               start;
    logic               run_iter;
    logic [31:0]        q_mag;
    logic [31:0]        d_mag;
    logic signed [32:0] prem;
    logic [5:0]         iter_cnt;
    logic [5:0]         add_cnt;
    logic [5:0]         sub_cnt;
    logic               neg_q;
    logic               neg_r;
    logic [32:0]        shifted;
    logic [32:0]        prem_step;
    logic [31:0]        r_mag;
    logic [31:0]        q_res;
    logic [31:0]        r_res;
    logic [5:0]         add_res;
    logic [5:0]         sub_res;
`ifdef DIVZERO_DETECT_EN
    logic               dz;
`endif

    function automatic logic [31:0] mag(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

    assign start = signal_in && ((state == IDLE) || (state == DONE));

`ifdef DIVZERO_DETECT_EN
    assign run_iter = (state == RUN) && !dz;
`else
    assign run_iter = (state == RUN);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (signal_in) state_nxt = RUN;
            end
            RUN: begin
`ifdef DIVZERO_DETECT_EN
                if (dz) state_nxt = FIX;
                else
`endif
                if (iter_cnt == 6'd1) state_nxt = FIX;
            end
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done_signal = (state == IDLE) || (state == DONE);
    end

    // The 33-bit remainder never exceeds 32 significant bits before the shift, so dropping prem[32] is lossless.
    always_comb begin
        shifted   = {prem[31:0], q_mag[31]};
        prem_step = prem[32] ? (shifted + {1'b0, d_mag}) : (shifted - {1'b0, d_mag});
        r_mag     = prem[32] ? (prem[31:0] + d_mag) : prem[31:0];
        q_res     = neg_q ? -q_mag : q_mag;
        r_res     = neg_r ? -r_mag : r_mag;
        add_res   = add_cnt + {5'd0, prem[32]};
        sub_res   = sub_cnt;
`ifdef DIVZERO_DETECT_EN
        // RUN was skipped, so q_mag still holds |dividend| and the sign fix rebuilds the dividend.
        if (dz) begin
            q_res   = 32'hFFFF_FFFF;
            r_res   = neg_r ? -q_mag : q_mag;
            add_res = 6'd0;
            sub_res = 6'd0;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_mag     <= '0;
            d_mag     <= '0;
            prem      <= '0;
            iter_cnt  <= '0;
            add_cnt   <= '0;
            sub_cnt   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            addOP     <= '0;
            subOP     <= '0;
`ifdef DIVZERO_DETECT_EN
            dz          <= 1'b0;
            div_by_zero <= 1'b0;
`endif
        end else if (start) begin
            q_mag    <= mag(dividend);
            d_mag    <= mag(divisor);
            prem     <= '0;
            iter_cnt <= 6'd32;
            add_cnt  <= '0;
            sub_cnt  <= '0;
            neg_q    <= dividend[31] ^ divisor[31];
            neg_r    <= dividend[31];
`ifdef DIVZERO_DETECT_EN
            dz          <= (divisor == 32'sd0);
            div_by_zero <= 1'b0;
`endif
        end else if (run_iter) begin
            prem     <= prem_step;
            q_mag    <= {q_mag[30:0], ~prem_step[32]};
            iter_cnt <= iter_cnt - 6'd1;
            if (prem[32]) add_cnt <= add_cnt + 6'd1;
            else          sub_cnt <= sub_cnt + 6'd1;
        end else if (state == FIX) begin
            quotient  <= q_res;
            remainder <= r_res;
            addOP     <= add_res;
            subOP     <= sub_res;
`ifdef DIVZERO_DETECT_EN
            div_by_zero <= dz;
`endif
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed bench for nonrestoring_divider: a plain-arithmetic model predicts every output each cycle.
module tb_nonrestoring_divider;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic signed [31:0] dividend = '0;
    logic signed [31:0] divisor = '0;
    logic               signal_in = 1'b0;
    logic signed [31:0] quotient;
    logic signed [31:0] remainder;
    logic               done_signal;
    logic [5:0]         addOP;
    logic [5:0]         subOP;
`ifdef DIVZERO_DETECT_EN
    logic               div_by_zero;
    logic               exp_dz = 1'b0;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;
    logic [31:0] exp_q = '0;
    logic [31:0] exp_r = '0;
    logic [5:0]  exp_add = '0;
    logic [5:0]  exp_sub = '0;
    logic        exp_done = 1'b1;

    nonrestoring_divider dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .dividend    (dividend),
        .divisor     (divisor),
        .signal_in   (signal_in),
        .quotient    (quotient),
        .remainder   (remainder),
        .done_signal (done_signal),
        .addOP       (addOP),
        .subOP       (subOP)
`ifdef DIVZERO_DETECT_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference from the arithmetic definition; op counts follow from the quotient bits:
    // a step subtracts iff the previous quotient bit was 1 (the first step always subtracts),
    // and the final correction adds iff the last quotient bit is 0.
    task automatic model(input logic signed [31:0] a, input logic signed [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic [5:0] ad, output logic [5:0] sb,
                         output logic dz, output int lat);
        longint la, lb, lq, lr, lm;
        logic [31:0] qmag;
        int ones;
        la = a;
        lb = b;
        dz = 1'b0;
        lat = 33;
        if (b == 0) begin
            q = (a >= 0) ? 32'hFFFF_FFFF : 32'd1;
            r = a;
            qmag = 32'hFFFF_FFFF;
        end else begin
            lq = la / lb;
            lr = la % lb;
            q = lq[31:0];
            r = lr[31:0];
            lm = (lq < 0) ? -lq : lq;
            qmag = lm[31:0];
        end
        ones = $countones(qmag[31:1]);
        sb = 6'(1 + ones);
        ad = 6'(31 - ones + (qmag[0] ? 0 : 1));
`ifdef DIVZERO_DETECT_EN
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            ad = 6'd0;
            sb = 6'd0;
            dz = 1'b1;
            lat = 2;
        end
`endif
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("done_signal", {31'd0, done_signal}, {31'd0, exp_done});
            chk("quotient", quotient, exp_q);
            chk("remainder", remainder, exp_r);
            chk("addOP", {26'd0, addOP}, {26'd0, exp_add});
            chk("subOP", {26'd0, subOP}, {26'd0, exp_sub});
`ifdef DIVZERO_DETECT_EN
            chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_dz});
`endif
        end
    end

    // Busy cycles toggle signal_in and scramble operands to show they are ignored.
    task automatic run_div(input logic signed [31:0] a, input logic signed [31:0] b,
                           input bit lit, input logic [31:0] lq, input logic [31:0] lr,
                           input bit lops, input logic [5:0] lad, input logic [5:0] lsb);
        logic [31:0] mq, mr;
        logic [5:0]  mad, msb;
        logic        mdz;
        int          lat;
        model(a, b, mq, mr, mad, msb, mdz, lat);
        @(negedge clock);
        dividend = a;
        divisor = b;
        signal_in = 1'b1;
        @(posedge clock);
        #1 exp_done = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            signal_in = 1'($urandom_range(0, 1));
            dividend = $urandom;
            divisor = $urandom;
            @(posedge clock);
        end
        #1;
        exp_q = mq;
        exp_r = mr;
        exp_add = mad;
        exp_sub = msb;
        exp_done = 1'b1;
`ifdef DIVZERO_DETECT_EN
        exp_dz = mdz;
`else
        if (mdz) $display("note: divisor-zero flag unexpected in this build");
`endif
        @(negedge clock);
        signal_in = 1'b0;
        if (lit) begin
            chk("lit_quotient", quotient, lq);
            chk("lit_remainder", remainder, lr);
        end
        if (lops) begin
            chk("lit_addOP", {26'd0, addOP}, {26'd0, lad});
            chk("lit_subOP", {26'd0, subOP}, {26'd0, lsb});
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic run_abort(input logic signed [31:0] a, input logic signed [31:0] b);
        @(negedge clock);
        dividend = a;
        divisor = b;
        signal_in = 1'b1;
        @(posedge clock);
        #1 exp_done = 1'b0;
        @(negedge clock);
        signal_in = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_addOP", {26'd0, addOP}, 32'd0);
        chk("rst_subOP", {26'd0, subOP}, 32'd0);
        chk("rst_done", {31'd0, done_signal}, 32'd1);
        exp_q = '0;
        exp_r = '0;
        exp_add = '0;
        exp_sub = '0;
        exp_done = 1'b1;
`ifdef DIVZERO_DETECT_EN
        exp_dz = 1'b0;
`endif
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        chk_en = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        run_div(100, 7, 1, 32'd14, 32'd2, 1, 6'd29, 6'd4);
        run_div(-100, 7, 1, -32'sd14, -32'sd2, 0, '0, '0);
        run_div(100, -7, 1, -32'sd14, 32'd2, 0, '0, '0);
        run_div(-100, -7, 1, 32'd14, -32'sd2, 0, '0, '0);
        run_div(0, 1, 1, 32'd0, 32'd0, 1, 6'd32, 6'd1);
        run_div(32'sh8000_0000, -1, 1, 32'h8000_0000, 32'd0, 0, '0, '0);
        run_div(20000, 0, 1, 32'hFFFF_FFFF, 32'd20000, 0, '0, '0);
        run_div(-20000, 0, 0, '0, '0, 0, '0, '0);
        run_div(7, 100, 1, 32'd0, 32'd7, 0, '0, '0);
        run_div(32'sh7FFF_FFFF, 1, 1, 32'h7FFF_FFFF, 32'd0, 0, '0, '0);
        run_div(32'sh8000_0000, 32'sh7FFF_FFFF, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, '0, '0);
        run_div(5, 32'sh8000_0000, 1, 32'd0, 32'd5, 0, '0, '0);
        run_div(32'sh8000_0000, 2, 1, 32'hC000_0000, 32'd0, 0, '0, '0);
        run_div(-1, 3, 1, 32'd0, 32'hFFFF_FFFF, 0, '0, '0);

        run_abort(123456, 3);
        run_div(123456, 3, 1, 32'd41152, 32'd0, 0, '0, '0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
